spmv_row_accumulator: RTL and testbench
=======================================

Name: spmv_row_accumulator

Overview:
- Sits directly downstream of the SpMV product stage and consumes its PARALLELISM-lane product beats.
- Each accepted beat is reduced with an adder tree over the lanes selected by a per-beat lane mask, then added into a running row accumulator.
- When a beat is flagged last-of-row, the block emits one result: the row sum, the row index and the count of products summed.
- Fixed-point/integer only: two's-complement wrap-around. The float path is a separate block.

Parameters:
- DATA_WIDTH, 16: width of each product and of the row sum.
- PARALLELISM, 4: lanes per input beat; must match the product stage.
- ROW_WIDTH, 16: width of the row index.
- CNT_WIDTH, 16: width of the per-row product count.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- prod  in  DATA_WIDTH x PARALLELISM  product lanes, unpacked array [PARALLELISM-1:0]
- lane_en  in  PARALLELISM  lane i contributes iff lane_en[i]
- in_last  in  1  beat is the final beat of its row
- in_row  in  ROW_WIDTH  row index; sampled on the last beat only
- sum  out  DATA_WIDTH  row sum
- sum_row  out  ROW_WIDTH  row index of sum
- sum_cnt  out  CNT_WIDTH  number of enabled lanes summed over the row
- valid  out  1  result valid
- ready  in  1  downstream accepts result when valid && ready

Behaviour:
- Reset (async assert, sync release):
  - valid=0; sum, sum_row, sum_cnt = 0.
  - acc=0, cnt=0, state=IDLE.
  - Asserting reset mid-row discards the partial row; nothing is emitted for it.
- in_ready = !valid || ready.
  - Purely registered-state plus ready; it must not depend on in_valid or in_last.
  - Beats are stalled only while a result is held and not taken.
- Beat reduction (combinational):
  - bsum = sum of prod[i] over i with lane_en[i], modulo 2^DATA_WIDTH.
  - bcnt = popcount(lane_en).
- States:
  - IDLE: no row in progress.
  - ACCUM: partial row held in acc/cnt.
- On an accepted beat with in_last=0:
  - acc <= acc + bsum, cnt <= cnt + bcnt.
  - In IDLE, acc <= bsum and cnt <= bcnt instead.
  - state <= ACCUM.
- On an accepted beat with in_last=1:
  - Next cycle: sum <= acc + bsum (acc treated as 0 in IDLE), sum_cnt <= cnt + bcnt, sum_row <= in_row, valid <= 1.
  - Then acc <= 0, cnt <= 0, state <= IDLE.
  - Latency: result visible 1 cycle after the last beat's handshake.
- Single-beat rows (IDLE with in_last=1) are legal.
- Empty rows (in_last=1, lane_en=0, from IDLE) emit sum=0, sum_cnt=0.
- Output holding:
  - valid && !ready: sum, sum_row, sum_cnt and valid hold stable.
  - valid && ready with no new last beat accepted the same cycle: valid <= 0.
  - valid && ready with a last beat accepted the same cycle: valid stays 1 and the new result loads (back-to-back rows, one result per cycle).
- Non-last beats are accepted under the same in_ready rule as last beats.
- Overflow: acc and sum wrap modulo 2^DATA_WIDTH. sum_cnt wraps modulo 2^CNT_WIDTH. No saturation and no flag.
- Lanes with lane_en=0 are ignored regardless of prod value (X-safe: must not propagate X into acc).
- in_row on non-last beats is don't-care.

Test Plan:
- Reset, then one beat: prod={1,2,3,4}, lane_en=4'b1111, in_last=1, in_row=7, ready=1.
  - Required: next cycle valid=1, sum=10, sum_row=7, sum_cnt=4; the cycle after, valid=0.
- Three-beat row with masks 4'b1111, 4'b0011, 4'b1000.
  - Beat values: {1,1,1,1}, {5,5,X,X}, {X,X,X,9}; last beat in_row=3.
  - Required: sum=23, sum_cnt=7, sum_row=3, and no X on any output.
- Backpressure: ready=0 when result sum=10 appears; hold ready low 5 cycles while in_valid=1.
  - Required: in_ready=0, outputs stable for those 5 cycles.
  - On ready=1: result is taken, in_ready=1 the same cycle, and the pending beat is accepted.
- Back-to-back single-beat rows 0..3 with ready=1 continuously, each beat lanes {r,r,r,r} for row r.
  - Required: valid high for 4 consecutive cycles, sums 0,4,8,12 with matching sum_row.
- Wrap and empty row (DATA_WIDTH=16):
  - Lanes {0x8000,0x8000,0x0001,0x0000}, all enabled, last → sum=0x0001.
  - Next, lane_en=0 with last → sum=0, sum_cnt=0.
- Reset mid-row: after 2 non-last beats, pulse rst_n low asynchronously mid-cycle.
  - Required: valid=0 immediately.
  - A following single last beat {2,2,2,2} emits sum=8, sum_cnt=4, with no residue from the partial row.

Source files
------------

// File: rtl/spmv_row_accumulator.sv
// SpMV row accumulator: reduces masked product lanes per beat and sums beats into per-row results.
module spmv_row_accumulator #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PARALLELISM = 4,
    parameter int unsigned ROW_WIDTH   = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] prod [PARALLELISM-1:0],
    input  logic [PARALLELISM-1:0] lane_en,
    input  logic                  in_last,
    input  logic [ROW_WIDTH-1:0]  in_row,
    output logic [DATA_WIDTH-1:0] sum,
    output logic [ROW_WIDTH-1:0]  sum_row,
    output logic [CNT_WIDTH-1:0]  sum_cnt,
    output logic                  valid,
    input  logic                  ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [ROW_WIDTH-1:0]  row_q, row_d;
    logic [CNT_WIDTH-1:0]  scnt_q, scnt_d;
    logic                  valid_q, valid_d;

    logic [DATA_WIDTH-1:0] bsum;
    logic [CNT_WIDTH-1:0]  bcnt;
    logic [DATA_WIDTH-1:0] acc_base;
    logic [CNT_WIDTH-1:0]  cnt_base;
    logic                  accept;

    // Stall beats only while a result is held and not being taken
    assign in_ready = !valid_q || ready;
    assign accept   = in_valid && in_ready;

    assign sum     = sum_q;
    assign sum_row = row_q;
    assign sum_cnt = scnt_q;
    assign valid   = valid_q;

    // Masked lane reduction; disabled lanes are ANDed to zero so X never reaches the adder
    always_comb begin
        bsum = '0;
        bcnt = '0;
        for (int unsigned i = 0; i < PARALLELISM; i++) begin
            bsum = bsum + (prod[i] & {DATA_WIDTH{lane_en[i]}});
            bcnt = bcnt + CNT_WIDTH'(lane_en[i]);
        end
    end

    // Next-state and result update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        row_d    = row_q;
        scnt_d   = scnt_q;
        valid_d  = valid_q;
        acc_base = (state_q == ACCUM) ? acc_q : '0;
        cnt_base = (state_q == ACCUM) ? cnt_q : '0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (in_last) begin
                sum_d   = acc_base + bsum;
                scnt_d  = cnt_base + bcnt;
                row_d   = in_row;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                acc_d   = acc_base + bsum;
                cnt_d   = cnt_base + bcnt;
                state_d = ACCUM;
            end
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            row_q   <= '0;
            scnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            row_q   <= row_d;
            scnt_q  <= scnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Self-checking bench for spmv_row_accumulator: directed vector table, corner sequences, randomized model check.
module tb_spmv_row_accumulator;

    localparam int unsigned DW = 16;
    localparam int unsigned P  = 4;
    localparam int unsigned RW = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] prod [P-1:0];
    logic [P-1:0]  lane_en;
    logic          in_last;
    logic [RW-1:0] in_row;
    logic [DW-1:0] sum;
    logic [RW-1:0] sum_row;
    logic [CW-1:0] sum_cnt;
    logic          valid;
    logic          ready;

    int total = 0;
    int bad   = 0;

    spmv_row_accumulator #(
        .DATA_WIDTH (DW),
        .PARALLELISM(P),
        .ROW_WIDTH  (RW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .prod    (prod),
        .lane_en (lane_en),
        .in_last (in_last),
        .in_row  (in_row),
        .sum     (sum),
        .sum_row (sum_row),
        .sum_cnt (sum_cnt),
        .valid   (valid),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] p [4];
        logic [P-1:0]  en;
        logic          last;
        logic [RW-1:0] row;
        logic          exp_valid;
        logic [DW-1:0] exp_sum;
        logic [RW-1:0] exp_row;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [DW-1:0] s;
        logic [RW-1:0] r;
        logic [CW-1:0] c;
    } res_t;

    vec_t vecs [10];
    res_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] d,
                            input logic [P-1:0] en, input logic last, input logic [RW-1:0] row);
        prod[0] = a; prod[1] = b; prod[2] = c; prod[3] = d;
        lane_en = en; in_last = last; in_row = row; in_valid = 1'b1;
    endtask

    task automatic set_vec(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [DW-1:0] d, input logic [P-1:0] en,
                           input logic last, input logic [RW-1:0] row, input logic ev,
                           input logic [DW-1:0] es, input logic [RW-1:0] er, input logic [CW-1:0] ec);
        vecs[i].p[0] = a; vecs[i].p[1] = b; vecs[i].p[2] = c; vecs[i].p[3] = d;
        vecs[i].en = en; vecs[i].last = last; vecs[i].row = row;
        vecs[i].exp_valid = ev; vecs[i].exp_sum = es; vecs[i].exp_row = er; vecs[i].exp_cnt = ec;
    endtask

    initial begin
        int m_sum;
        int m_cnt;
        logic          held;
        logic [DW-1:0] h_sum;
        logic [RW-1:0] h_row;
        logic [CW-1:0] h_cnt;
        res_t          e;
        res_t          r;

        rst_n = 1'b0; in_valid = 1'b0; ready = 1'b1; lane_en = '0; in_last = 1'b0; in_row = '0;
        for (int j = 0; j < int'(P); j++) prod[j] = '0;

        // Directed table: one beat per entry, result checked one cycle later
        set_vec(0, 16'd1, 16'd2, 16'd3, 16'd4, 4'b1111, 1'b1, 16'd7, 1'b1, 16'd10, 16'd7, 16'd4);
        set_vec(1, 16'd1, 16'd1, 16'd1, 16'd1, 4'b1111, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 16'd0);
        set_vec(2, 16'd5, 16'd5, 'x, 'x, 4'b0011, 1'b0, 'x, 1'b0, 16'd0, 16'd0, 16'd0);
        set_vec(3, 'x, 'x, 'x, 16'd9, 4'b1000, 1'b1, 16'd3, 1'b1, 16'd23, 16'd3, 16'd7);
        set_vec(4, 16'd0, 16'd0, 16'd0, 16'd0, 4'b1111, 1'b1, 16'd0, 1'b1, 16'd0, 16'd0, 16'd4);
        set_vec(5, 16'd1, 16'd1, 16'd1, 16'd1, 4'b1111, 1'b1, 16'd1, 1'b1, 16'd4, 16'd1, 16'd4);
        set_vec(6, 16'd2, 16'd2, 16'd2, 16'd2, 4'b1111, 1'b1, 16'd2, 1'b1, 16'd8, 16'd2, 16'd4);
        set_vec(7, 16'd3, 16'd3, 16'd3, 16'd3, 4'b1111, 1'b1, 16'd3, 1'b1, 16'd12, 16'd3, 16'd4);
        set_vec(8, 16'h8000, 16'h8000, 16'h0001, 16'h0000, 4'b1111, 1'b1, 16'd9, 1'b1, 16'h0001, 16'd9, 16'd4);
        set_vec(9, 16'h1234, 16'hffff, 'x, 16'h0042, 4'b0000, 1'b1, 16'd10, 1'b1, 16'd0, 16'd10, 16'd0);

        step(); step();
        #2 rst_n = 1'b1;
        step();
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_row", 32'(sum_row), 32'd0);
        chk("reset_cnt", 32'(sum_cnt), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            set_beat(vecs[i].p[0], vecs[i].p[1], vecs[i].p[2], vecs[i].p[3],
                     vecs[i].en, vecs[i].last, vecs[i].row);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
                chk($sformatf("vec%0d_row", i), 32'(sum_row), 32'(vecs[i].exp_row));
                chk($sformatf("vec%0d_cnt", i), 32'(sum_cnt), 32'(vecs[i].exp_cnt));
                chk($sformatf("vec%0d_noX", i), 32'($isunknown({sum, sum_row, sum_cnt, valid})), 32'd0);
            end
        end
        in_valid = 1'b0;
        step();
        chk("idle_valid_drop", 32'(valid), 32'd0);

        // Backpressure: result held 5 cycles, pending beat stalled then accepted on release
        set_beat(16'd1, 16'd2, 16'd3, 16'd4, 4'b1111, 1'b1, 16'd5);
        step();
        set_beat(16'd2, 16'd2, 16'd2, 16'd2, 4'b1111, 1'b1, 16'd6);
        ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", {valid, sum, sum_row[14:0]}, {1'b1, 16'd10, 15'd5});
            step();
        end
        ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(valid), 32'd1);
        chk("bp_next_sum", 32'(sum), 32'd8);
        chk("bp_next_row", 32'(sum_row), 32'd6);
        step();
        chk("bp_drain", 32'(valid), 32'd0);

        // Reset mid-row: a completed result and a partial row both vanish
        set_beat(16'd7, 16'd7, 16'd7, 16'd7, 4'b1111, 1'b1, 16'd11);
        step();
        set_beat(16'd100, 16'd100, 16'd100, 16'd100, 4'b1111, 1'b0, 16'd0);
        step();
        set_beat(16'd50, 16'd50, 16'd50, 16'd50, 4'b0111, 1'b0, 16'd0);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(valid), 32'd0);
        chk("rst_mid_sum", 32'(sum), 32'd0);
        chk("rst_mid_row", 32'(sum_row), 32'd0);
        #2 rst_n = 1'b1;
        step();
        set_beat(16'd2, 16'd2, 16'd2, 16'd2, 4'b1111, 1'b1, 16'd12);
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(valid), 32'd1);
        chk("post_rst_sum", 32'(sum), 32'd8);
        chk("post_rst_cnt", 32'(sum_cnt), 32'd4);
        step();

        // Randomized traffic against a row-level reference model
        m_sum = 0; m_cnt = 0; held = 1'b0;
        h_sum = '0; h_row = '0; h_cnt = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c < 2900) begin
                in_valid = ($urandom_range(0, 3) != 0);
                lane_en  = P'($urandom);
                for (int j = 0; j < int'(P); j++) prod[j] = DW'($urandom);
                in_last  = ($urandom_range(0, 2) == 0);
                in_row   = RW'($urandom);
                ready    = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0;
                ready    = 1'b1;
            end
            @(negedge clk);
            if (held) begin
                chk("rnd_hold", {valid, sum, sum_row[7:0], sum_cnt[6:0]},
                    {1'b1, h_sum, h_row[7:0], h_cnt[6:0]});
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_result", 32'(valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    r.s = sum; r.r = sum_row; r.c = sum_cnt;
                    chk("rnd_sum", 32'(r.s), 32'(e.s));
                    chk("rnd_row", 32'(r.r), 32'(e.r));
                    chk("rnd_cnt", 32'(r.c), 32'(e.c));
                end
            end
            held = valid && !ready;
            h_sum = sum; h_row = sum_row; h_cnt = sum_cnt;
            if (in_valid && in_ready) begin
                for (int j = 0; j < int'(P); j++) if (lane_en[j]) m_sum += int'(prod[j]);
                m_cnt += $countones(lane_en);
                if (in_last) begin
                    e.s = DW'(m_sum); e.r = in_row; e.c = CW'(m_cnt);
                    exp_q.push_back(e);
                    m_sum = 0; m_cnt = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rnd_final_valid", 32'(valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
